ladybird_ifu_prefetch: RTL and testbench

LADYBIRD_IFU_PREFETCH -- requirements
Module: ladybird_ifu_prefetch

---
 rtl/ladybird_ifu_prefetch.sv | 181 ++++++++++++++++++
 tb/tb_ladybird_ifu_prefetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ladybird_ifu_prefetch.sv
// rtl/ladybird_ifu_prefetch.sv - instruction prefetcher with credit-limited fetch, in-order pending queue and output FIFO
// Optional perf counters enabled by defining LADYBIRD_IFU_PERF_EN.
module ladybird_ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              LINE_W   = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              cache_req,
    output logic [XLEN-1:0]   cache_addr,
    input  logic              cache_ready,
    input  logic              cache_resp_valid,
    input  logic [LINE_W-1:0] cache_resp_data,
    output logic [XLEN-1:0]   inst,
    output logic [XLEN-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
`ifdef LADYBIRD_IFU_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int BYTES   = XLEN / 8;
    localparam int NWORDS  = LINE_W / XLEN;
    localparam int SEL_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int OFF_LSB = $clog2(BYTES);

    logic            r_run;
    logic [XLEN-1:0] r_pc;

    logic [XLEN-1:0] r_pend_addr [DEPTH];
    logic [AW-1:0]   r_pend_wptr;
    logic [AW-1:0]   r_pend_rptr;
    logic [CW-1:0]   r_pend_cnt;

    logic [XLEN-1:0] r_fifo_addr [DEPTH];
    logic [XLEN-1:0] r_fifo_word [DEPTH];
    logic [AW-1:0]   r_fifo_wptr;
    logic [AW-1:0]   r_fifo_rptr;
    logic [CW-1:0]   r_fifo_cnt;

    logic [CW-1:0]   r_discard;

    logic [CW:0]      w_used;
    logic             w_credit;
    logic             w_accept;
    logic             w_resp;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_fifo_ne;
    logic [XLEN-1:0]  w_pend_head;
    logic [SEL_W-1:0] w_sel;
    logic [XLEN-1:0]  w_word;
    logic             w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};

    // Occupancy plus in-flight requests never exceeds DEPTH, so the FIFO cannot overflow.
    assign w_used    = {1'b0, r_fifo_cnt} + {1'b0, r_pend_cnt};
    assign w_credit  = (w_used < (CW+1)'(DEPTH));
    assign cache_req = r_run & ~redirect_valid & w_credit;
    assign cache_addr = r_pc;
    assign w_accept  = cache_req & cache_ready;

    assign w_resp    = cache_resp_valid & (r_pend_cnt != '0);
    assign w_drop    = redirect_valid | (r_discard != '0);
    assign w_push    = w_resp & ~w_drop;

    assign w_fifo_ne  = (r_fifo_cnt != '0);
    assign inst_valid = w_fifo_ne & ~redirect_valid;
    assign w_pop      = inst_valid & inst_ready;
    assign inst       = w_fifo_ne ? r_fifo_word[r_fifo_rptr] : '0;
    assign inst_pc    = w_fifo_ne ? r_fifo_addr[r_fifo_rptr] : '0;

    assign w_pend_head = r_pend_addr[r_pend_rptr];

    generate
        if (NWORDS > 1) begin : g_sel
            assign w_sel = w_pend_head[OFF_LSB +: SEL_W];
        end else begin : g_nosel
            assign w_sel = '0;
        end
    endgenerate

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_word = cache_resp_data[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_run       <= 1'b0;
            r_pc        <= RESET_PC;
            r_pend_wptr <= '0;
            r_pend_rptr <= '0;
            r_pend_cnt  <= '0;
            r_fifo_wptr <= '0;
            r_fifo_rptr <= '0;
            r_fifo_cnt  <= '0;
            r_discard   <= '0;
        end else begin
            r_run <= 1'b1;

            if (redirect_valid) begin
                r_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (w_accept) begin
                r_pc <= r_pc + XLEN'(BYTES);
            end

            if (w_accept) begin
                r_pend_addr[r_pend_wptr] <= r_pc;
                r_pend_wptr              <= r_pend_wptr + AW'(1);
            end
            if (w_resp) begin
                r_pend_rptr <= r_pend_rptr + AW'(1);
            end
            r_pend_cnt <= r_pend_cnt + CW'(w_accept) - CW'(w_resp);

            // Every request still in flight after a redirect is stale, including ones already marked.
            if (redirect_valid) begin
                r_discard <= r_pend_cnt - CW'(w_resp);
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - CW'(1);
            end

            if (redirect_valid) begin
                r_fifo_rptr <= r_fifo_wptr;
                r_fifo_cnt  <= '0;
            end else begin
                if (w_push) begin
                    r_fifo_addr[r_fifo_wptr] <= w_pend_head;
                    r_fifo_word[r_fifo_wptr] <= w_word;
                    r_fifo_wptr              <= r_fifo_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_fifo_rptr <= r_fifo_rptr + AW'(1);
                end
                r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef LADYBIRD_IFU_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_perf_fetch <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_accept && (r_perf_fetch != '1)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (redirect_valid && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_flush_cnt = r_perf_flush;
`endif

    a_resp_has_pending: assert property (@(posedge clk) disable iff (!nrst)
        !(cache_resp_valid && (r_pend_cnt == '0)));

endmodule

// File: tb/tb_ladybird_ifu_prefetch.sv
// tb/tb_ladybird_ifu_prefetch.sv - directed self-checking bench for ladybird_ifu_prefetch
module tb_ladybird_ifu_prefetch;

    logic        clk;
    logic        nrst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic        cache_ready;
    logic        cache_resp_valid;
    logic [63:0] cache_resp_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
`ifdef LADYBIRD_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ladybird_ifu_prefetch #(
        .XLEN     (32),
        .LINE_W   (64),
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .cache_req        (cache_req),
        .cache_addr       (cache_addr),
        .cache_ready      (cache_ready),
        .cache_resp_valid (cache_resp_valid),
        .cache_resp_data  (cache_resp_data),
        .inst             (inst),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready)
`ifdef LADYBIRD_IFU_PERF_EN
        ,
        .perf_fetch_cnt   (perf_fetch_cnt),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int lat      = 0;
    int acc_total = 0;
    int acc0     = 0;
    logic [31:0] q_addr [$];
    int          q_due  [$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        if (a[31:3] == 29'd0) return a[2] ? 32'hBBBBBBBB : 32'hAAAAAAAA;
        return {a[31:2], 2'b00} ^ 32'h5A5A0000;
    endfunction

    function automatic logic [63:0] line_of(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:3], 3'b000};
        return {word_of(b | 32'h4), word_of(b)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample acceptance, advance, then update the cache model at the negedge.
    task automatic cyc();
        logic        acc;
        logic        rsp;
        logic [31:0] a;
        #1;
        acc = cache_req & cache_ready;
        a   = cache_addr;
        rsp = cache_resp_valid;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        if (!nrst) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (rsp && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (acc === 1'b1) begin
                q_addr.push_back(a);
                q_due.push_back(cyc_n + lat);
                acc_total++;
            end
        end
        if (q_addr.size() > 0 && q_due[0] <= cyc_n) begin
            cache_resp_valid = 1'b1;
            cache_resp_data  = line_of(q_addr[0]);
        end else begin
            cache_resp_valid = 1'b0;
            cache_resp_data  = '0;
        end
        #1;
    endtask

    task automatic wait_inst(input string tag, input int bound);
        for (int i = 0; i < bound && inst_valid !== 1'b1; i++) cyc();
        chk(tag, inst_valid, 1);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        #1;
        chk("redir_inst_valid_low", inst_valid, 0);
        chk("redir_req_low", cache_req, 0);
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        nrst             = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        cache_ready      = 1'b0;
        cache_resp_valid = 1'b0;
        cache_resp_data  = '0;
        inst_ready       = 1'b1;

        // reset state
        cyc(); cyc(); cyc();
        chk("rst_req", cache_req, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_addr", cache_addr, 32'h100);
`ifdef LADYBIRD_IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 0);
        chk("rst_perf_flush", perf_flush_cnt, 0);
`endif

        // cache stalls: request held stable for 5 cycles
        nrst = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", cache_req, 1);
            chk("stall_addr", cache_addr, 32'h100);
`ifdef LADYBIRD_IFU_PERF_EN
            chk("stall_perf", perf_fetch_cnt, 0);
`endif
            cyc();
        end
        cache_ready = 1'b1;
        cyc();
        chk("post_accept_addr", cache_addr, 32'h104);
`ifdef LADYBIRD_IFU_PERF_EN
        chk("post_accept_perf", perf_fetch_cnt, 1);
`endif

        // streaming with zero-latency cache, one instruction per cycle
        wait_inst("stream_first_valid", 10);
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", inst_valid, 1);
            chk("stream_pc", inst_pc, 32'h100 + 32'(4*i));
            chk("stream_inst", inst, word_of(32'h100 + 32'(4*i)));
            cyc();
        end

        // consumer stalled: exactly DEPTH requests, then one more per pop
        inst_ready = 1'b0;
        do_redirect(32'h400);
        acc0 = acc_total;
        for (int i = 0; i < 12; i++) cyc();
        chk("full_accepts", acc_total - acc0, 4);
        chk("full_req_low", cache_req, 0);
        chk("full_head_pc", inst_pc, 32'h400);
        chk("full_head_inst", inst, word_of(32'h400));
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        acc0 = acc_total;
        for (int i = 0; i < 8; i++) cyc();
        chk("pop_one_accept", acc_total - acc0, 1);
        chk("pop_req_low", cache_req, 0);
        chk("pop_head_pc", inst_pc, 32'h404);

        // word selection within a 64-bit line
        inst_ready = 1'b1;
        do_redirect(32'h0);
        wait_inst("sel_valid", 10);
        chk("sel_pc0", inst_pc, 32'h0);
        chk("sel_inst0", inst, 32'hAAAAAAAA);
        cyc();
        chk("sel_pc4", inst_pc, 32'h4);
        chk("sel_inst4", inst, 32'hBBBBBBBB);
        cyc();
        chk("sel_pc8", inst_pc, 32'h8);
        chk("sel_inst8", inst, 32'h5A5A0008);

        // redirect with 3 outstanding requests
        lat = 6;
        do_redirect(32'h800);
        acc0 = acc_total;
        for (int i = 0; i < 10 && (acc_total - acc0) < 3; i++) cyc();
        cache_ready = 1'b0;
        chk("three_outstanding", acc_total - acc0, 3);
        cache_ready = 1'b1;
        do_redirect(32'h2002);
        lat = 0;
        wait_inst("flush_valid", 30);
        chk("flush_pc0", inst_pc, 32'h2000);
        chk("flush_inst0", inst, word_of(32'h2000));
        cyc();
        chk("flush_pc1", inst_pc, 32'h2004);
        cyc();
        chk("flush_pc2", inst_pc, 32'h2008);

        // second redirect while earlier discards are still pending
        lat = 6;
        do_redirect(32'h3000);
        acc0 = acc_total;
        for (int i = 0; i < 10 && (acc_total - acc0) < 3; i++) cyc();
        cache_ready = 1'b0;
        chk("g_three_outstanding", acc_total - acc0, 3);
        cache_ready = 1'b1;
        do_redirect(32'h5000);
        cyc();
        cyc();
        do_redirect(32'h6000);
        lat = 0;
        wait_inst("double_valid", 40);
        chk("double_pc0", inst_pc, 32'h6000);
        chk("double_inst0", inst, word_of(32'h6000));
        cyc();
        chk("double_pc1", inst_pc, 32'h6004);
`ifdef LADYBIRD_IFU_PERF_EN
        chk("perf_flush", perf_flush_cnt, 7);
`endif

        // reset in the middle of streaming
        nrst = 1'b0;
        cyc();
        cyc();
        chk("midrst_req", cache_req, 0);
        chk("midrst_valid", inst_valid, 0);
        chk("midrst_pc", inst_pc, 0);
`ifdef LADYBIRD_IFU_PERF_EN
        chk("midrst_perf_fetch", perf_fetch_cnt, 0);
        chk("midrst_perf_flush", perf_flush_cnt, 0);
`endif
        nrst = 1'b1;
        wait_inst("midrst_restart_valid", 10);
        chk("midrst_restart_pc", inst_pc, 32'h100);
        chk("midrst_restart_inst", inst, word_of(32'h100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
